// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB channel encoder path: phase constants,
// the transition class and the clockwise-successor helper.
package rgb_pkg;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  typedef enum logic [1:0] {
    TR_NONE,
    TR_CW,
    TR_CCW,
    TR_ILLEGAL
  } trans_e;

  // Phase that follows the given one after a single clockwise edge: 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic [1:0] cw_next(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH_00:   nxt = PH_10;
      PH_10:   nxt = PH_11;
      PH_11:   nxt = PH_01;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_classify.sv
// Combinational classifier of one step between two consecutive phase samples.
module quad_classify
  import rgb_pkg::*;
(
  input  logic [1:0] i_ab_p,
  input  logic [1:0] i_ab_q,
  output trans_e     o_trans
);

  // Anything that is neither a hold nor a single Gray step either way is illegal.
  always_comb begin
    o_trans = TR_ILLEGAL;
    if (i_ab_p == i_ab_q) begin
      o_trans = TR_NONE;
    end else if (i_ab_q == cw_next(i_ab_p)) begin
      o_trans = TR_CW;
    end else if (i_ab_p == cw_next(i_ab_q)) begin
      o_trans = TR_CCW;
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: accumulates Gray-code edges into detents and moves a
// WIDTH-bit channel value by STEP per detent, saturating or wrapping.
module quad_decoder
  import rgb_pkg::*;
#(
  parameter int WIDTH            = 8,
  parameter int STEP             = 1,
  parameter int EDGES_PER_DETENT = 4,
  parameter int WRAP             = 0,
  parameter int INIT             = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clear,
  output logic [WIDTH-1:0] value,
  output logic             up_pulse,
  output logic             down_pulse,
  output logic             err_pulse
);

  // Elaboration-time sanity checks on the parameter set.
  if (EDGES_PER_DETENT != 1 && EDGES_PER_DETENT != 2 && EDGES_PER_DETENT != 4) begin : g_bad_epd
    $error("quad_decoder: EDGES_PER_DETENT must be 1, 2 or 4");
  end
  if (STEP < 1 || (WIDTH < 31 && STEP >= (1 << WIDTH))) begin : g_bad_step
    $error("quad_decoder: STEP out of range");
  end
  if (INIT < 0 || (WIDTH < 31 && INIT >= (1 << WIDTH))) begin : g_bad_init
    $error("quad_decoder: INIT does not fit in WIDTH bits");
  end

  localparam logic signed [3:0] EDGES_POS = 4'(EDGES_PER_DETENT);
  localparam logic signed [3:0] EDGES_NEG = -EDGES_POS;
  localparam logic [WIDTH:0]    STEP_X    = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0]  INIT_V    = WIDTH'(INIT);

  logic [1:0]        r_ab_q;
  logic [1:0]        r_ab_p;
  logic              r_primed;
  logic signed [3:0] r_sub;
  logic [WIDTH-1:0]  r_value;
  logic              r_up;
  logic              r_down;
  logic              r_err;

  trans_e            w_trans;
  logic [WIDTH:0]    w_sum;
  logic [WIDTH:0]    w_diff;
  logic [WIDTH-1:0]  w_val_up;
  logic [WIDTH-1:0]  w_val_dn;
  logic signed [3:0] w_sub_inc;
  logic signed [3:0] w_sub_dec;

  quad_classify u_classify (
    .i_ab_p  (r_ab_p),
    .i_ab_q  (r_ab_q),
    .o_trans (w_trans)
  );

  // Candidate values one step up/down; the extra top bit flags carry or borrow.
  always_comb begin
    w_sum     = {1'b0, r_value} + STEP_X;
    w_diff    = {1'b0, r_value} - STEP_X;
    w_val_up  = (WRAP == 0 && w_sum[WIDTH])  ? '1 : w_sum[WIDTH-1:0];
    w_val_dn  = (WRAP == 0 && w_diff[WIDTH]) ? '0 : w_diff[WIDTH-1:0];
    w_sub_inc = r_sub + 4'sd1;
    w_sub_dec = r_sub - 4'sd1;
  end

  // Phase pipeline, priming, sub-count, value update and one-cycle pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ab_q   <= PH_00;
      r_ab_p   <= PH_00;
      r_primed <= 1'b0;
      r_sub    <= '0;
      r_value  <= INIT_V;
      r_up     <= 1'b0;
      r_down   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_ab_q <= {enc_a, enc_b};
      r_up   <= 1'b0;
      r_down <= 1'b0;
      r_err  <= 1'b0;
      if (!r_primed) begin
        r_ab_p   <= {enc_a, enc_b};
        r_primed <= 1'b1;
      end else begin
        r_ab_p <= r_ab_q;
        case (w_trans)
          TR_CW: begin
            if (w_sub_inc == EDGES_POS) begin
              r_sub   <= '0;
              r_up    <= 1'b1;
              r_value <= w_val_up;
            end else begin
              r_sub <= w_sub_inc;
            end
          end
          TR_CCW: begin
            if (w_sub_dec == EDGES_NEG) begin
              r_sub   <= '0;
              r_down  <= 1'b1;
              r_value <= w_val_dn;
            end else begin
              r_sub <= w_sub_dec;
            end
          end
          TR_ILLEGAL: begin
            r_sub <= '0;
            r_err <= 1'b1;
          end
          default: ;
        endcase
      end
      if (clear) begin
        r_value <= INIT_V;
        r_sub   <= '0;
      end
    end
  end

  assign value      = r_value;
  assign up_pulse   = r_up;
  assign down_pulse = r_down;
  assign err_pulse  = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: five parameterisations share one stimulus stream
// and are compared every cycle against a phase-position reference model.
module tb_quad_decoder;

  localparam int NI = 5;
  localparam int MAXV = 256;
  localparam int C_STEP [NI] = '{1, 16, 1, 3, 37};
  localparam int C_EPD  [NI] = '{4, 4, 4, 1, 2};
  localparam int C_WRAP [NI] = '{0, 0, 1, 1, 0};
  localparam int C_INIT [NI] = '{0, 240, 0, 100, 5};

  typedef struct {
    logic [1:0] ph;
    bit         clr;
    bit         rst;
    int         expVal;
    bit         expUp;
    bit         expDn;
    bit         expErr;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       encA = 1'b1;
  logic       encB = 1'b1;
  logic       clr = 1'b0;
  logic [7:0] dVal [NI];
  logic       dUp  [NI];
  logic       dDn  [NI];
  logic       dErr [NI];

  int tests = 0;
  int failed = 0;

  bit         mPrimed;
  logic [1:0] mSeen;
  logic [1:0] mLast;
  int         mVal [NI];
  int         mSub [NI];
  bit         mUp  [NI];
  bit         mDn  [NI];
  bit         mErr [NI];

  int         curPos = 2;
  logic [1:0] phTab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  vec_t       vecs [$];

  always #5 clk = ~clk;

  quad_decoder #(.WIDTH(8), .STEP(C_STEP[0]), .EDGES_PER_DETENT(C_EPD[0]), .WRAP(C_WRAP[0]), .INIT(C_INIT[0])) d0 (
    .clk(clk), .reset(reset), .enc_a(encA), .enc_b(encB), .clear(clr),
    .value(dVal[0]), .up_pulse(dUp[0]), .down_pulse(dDn[0]), .err_pulse(dErr[0]));
  quad_decoder #(.WIDTH(8), .STEP(C_STEP[1]), .EDGES_PER_DETENT(C_EPD[1]), .WRAP(C_WRAP[1]), .INIT(C_INIT[1])) d1 (
    .clk(clk), .reset(reset), .enc_a(encA), .enc_b(encB), .clear(clr),
    .value(dVal[1]), .up_pulse(dUp[1]), .down_pulse(dDn[1]), .err_pulse(dErr[1]));
  quad_decoder #(.WIDTH(8), .STEP(C_STEP[2]), .EDGES_PER_DETENT(C_EPD[2]), .WRAP(C_WRAP[2]), .INIT(C_INIT[2])) d2 (
    .clk(clk), .reset(reset), .enc_a(encA), .enc_b(encB), .clear(clr),
    .value(dVal[2]), .up_pulse(dUp[2]), .down_pulse(dDn[2]), .err_pulse(dErr[2]));
  quad_decoder #(.WIDTH(8), .STEP(C_STEP[3]), .EDGES_PER_DETENT(C_EPD[3]), .WRAP(C_WRAP[3]), .INIT(C_INIT[3])) d3 (
    .clk(clk), .reset(reset), .enc_a(encA), .enc_b(encB), .clear(clr),
    .value(dVal[3]), .up_pulse(dUp[3]), .down_pulse(dDn[3]), .err_pulse(dErr[3]));
  quad_decoder #(.WIDTH(8), .STEP(C_STEP[4]), .EDGES_PER_DETENT(C_EPD[4]), .WRAP(C_WRAP[4]), .INIT(C_INIT[4])) d4 (
    .clk(clk), .reset(reset), .enc_a(encA), .enc_b(encB), .clear(clr),
    .value(dVal[4]), .up_pulse(dUp[4]), .down_pulse(dDn[4]), .err_pulse(dErr[4]));

  // Position of a phase around the clockwise cycle 00,10,11,01.
  function automatic int phPos(input logic [1:0] ph);
    case (ph)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic vec_t mkVec(input logic [1:0] ph, input bit c, input bit r,
                                 input int v, input bit u, input bit d, input bit e);
    vec_t t;
    t.ph = ph; t.clr = c; t.rst = r;
    t.expVal = v; t.expUp = u; t.expDn = d; t.expErr = e;
    return t;
  endfunction

  // Reference model: the edge sampled last cycle is judged against the one
  // before it by its distance around the phase circle.
  task automatic modelEdge(input logic [1:0] ph, input bit c, input bit r);
    int d;
    if (r) begin
      mPrimed = 1'b0;
      mSeen = 2'b00;
      mLast = 2'b00;
      for (int i = 0; i < NI; i++) begin
        mVal[i] = C_INIT[i]; mSub[i] = 0;
        mUp[i] = 1'b0; mDn[i] = 1'b0; mErr[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        mUp[i] = 1'b0; mDn[i] = 1'b0; mErr[i] = 1'b0;
      end
      if (!mPrimed) begin
        mSeen = ph;
        mLast = ph;
        mPrimed = 1'b1;
      end else begin
        d = (phPos(mLast) - phPos(mSeen) + 4) % 4;
        for (int i = 0; i < NI; i++) begin
          if (d == 1) begin
            mSub[i] = mSub[i] + 1;
            if (mSub[i] == C_EPD[i]) begin
              mSub[i] = 0;
              mUp[i] = 1'b1;
              if (C_WRAP[i] != 0) mVal[i] = (mVal[i] + C_STEP[i]) % MAXV;
              else mVal[i] = (mVal[i] + C_STEP[i] > MAXV - 1) ? MAXV - 1 : mVal[i] + C_STEP[i];
            end
          end else if (d == 3) begin
            mSub[i] = mSub[i] - 1;
            if (mSub[i] == -C_EPD[i]) begin
              mSub[i] = 0;
              mDn[i] = 1'b1;
              if (C_WRAP[i] != 0) mVal[i] = (mVal[i] - C_STEP[i] + MAXV) % MAXV;
              else mVal[i] = (mVal[i] - C_STEP[i] < 0) ? 0 : mVal[i] - C_STEP[i];
            end
          end else if (d == 2) begin
            mSub[i] = 0;
            mErr[i] = 1'b1;
          end
        end
        mSeen = mLast;
        mLast = ph;
      end
      if (c) begin
        for (int i = 0; i < NI; i++) begin
          mVal[i] = C_INIT[i];
          mSub[i] = 0;
        end
      end
    end
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkModel();
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("d%0d value", i), int'(dVal[i]), mVal[i]);
      checkOutput($sformatf("d%0d up_pulse", i), int'(dUp[i]), int'(mUp[i]));
      checkOutput($sformatf("d%0d down_pulse", i), int'(dDn[i]), int'(mDn[i]));
      checkOutput($sformatf("d%0d err_pulse", i), int'(dErr[i]), int'(mErr[i]));
    end
  endtask

  // Drive one cycle of inputs away from the edge, then compare after it.
  task automatic applyStimulus(input logic [1:0] ph, input bit c, input bit r);
    @(negedge clk);
    {encA, encB} = ph;
    clr = c;
    reset = r;
    curPos = phPos(ph);
    @(posedge clk);
    modelEdge(ph, c, r);
    #1;
    checkModel();
  endtask

  initial begin
    int upCnt;
    int r;
    logic [1:0] cwSeq [4];
    cwSeq = '{2'b01, 2'b00, 2'b10, 2'b11};

    // Table for the default instance: reset at 11, one CW detent, two CW then
    // two CCW edges, an illegal 00->11 jump, then another full CW detent.
    vecs.push_back(mkVec(2'b11, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mkVec(2'b11, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(2'b01, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(2'b00, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(2'b10, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(2'b11, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(2'b11, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mkVec(2'b11, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mkVec(2'b01, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mkVec(2'b00, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mkVec(2'b01, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mkVec(2'b11, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mkVec(2'b11, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mkVec(2'b11, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mkVec(2'b01, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mkVec(2'b00, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mkVec(2'b11, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mkVec(2'b11, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mkVec(2'b01, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mkVec(2'b00, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mkVec(2'b10, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mkVec(2'b11, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mkVec(2'b11, 0, 0, 2, 1, 0, 0));
    vecs.push_back(mkVec(2'b11, 0, 0, 2, 0, 0, 0));

    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k].ph, vecs[k].clr, vecs[k].rst);
      checkOutput($sformatf("tbl[%0d] value", k), int'(dVal[0]), vecs[k].expVal);
      checkOutput($sformatf("tbl[%0d] up", k), int'(dUp[0]), int'(vecs[k].expUp));
      checkOutput($sformatf("tbl[%0d] down", k), int'(dDn[0]), int'(vecs[k].expDn));
      checkOutput($sformatf("tbl[%0d] err", k), int'(dErr[0]), int'(vecs[k].expErr));
    end

    // Seven CW detents: default reaches 7, STEP=16 instance saturates at 255.
    applyStimulus(2'b11, 0, 1);
    applyStimulus(2'b11, 0, 0);
    upCnt = 0;
    for (int k = 0; k < 7; k++) begin
      for (int j = 0; j < 4; j++) begin
        applyStimulus(cwSeq[j], 0, 0);
        if (dUp[1]) upCnt++;
      end
    end
    applyStimulus(2'b11, 0, 0);
    if (dUp[1]) upCnt++;
    checkOutput("seven detents d0 value", int'(dVal[0]), 7);
    checkOutput("saturate d1 value", int'(dVal[1]), 255);
    checkOutput("saturate d1 up count", upCnt, 7);

    // Clear in the same cycle the eighth detent completes.
    for (int j = 0; j < 4; j++) applyStimulus(cwSeq[j], 0, 0);
    applyStimulus(2'b11, 1, 0);
    checkOutput("clear+detent d0 up", int'(dUp[0]), 1);
    checkOutput("clear+detent d0 value", int'(dVal[0]), 0);
    checkOutput("clear+detent d4 value", int'(dVal[4]), 5);
    applyStimulus(2'b11, 0, 0);
    checkOutput("after clear d0 value", int'(dVal[0]), 0);

    // Reset held mid-detent, then a fresh detent must need all four edges.
    applyStimulus(2'b01, 0, 0);
    applyStimulus(2'b00, 0, 0);
    applyStimulus(2'b10, 0, 0);
    applyStimulus(2'b10, 0, 1);
    checkOutput("mid reset d0 value", int'(dVal[0]), 0);
    checkOutput("mid reset d1 value", int'(dVal[1]), 240);
    checkOutput("mid reset d3 value", int'(dVal[3]), 100);
    applyStimulus(2'b10, 0, 0);
    upCnt = 0;
    applyStimulus(2'b11, 0, 0); if (dUp[0]) upCnt++;
    applyStimulus(2'b01, 0, 0); if (dUp[0]) upCnt++;
    applyStimulus(2'b00, 0, 0); if (dUp[0]) upCnt++;
    applyStimulus(2'b10, 0, 0); if (dUp[0]) upCnt++;
    checkOutput("post reset early up count", upCnt, 0);
    applyStimulus(2'b10, 0, 0);
    checkOutput("post reset detent up", int'(dUp[0]), 1);

    // One CCW detent from reset: wrap to 255, saturate at 0, 240-16.
    applyStimulus(2'b00, 0, 1);
    applyStimulus(2'b00, 0, 0);
    applyStimulus(2'b01, 0, 0);
    applyStimulus(2'b11, 0, 0);
    applyStimulus(2'b10, 0, 0);
    applyStimulus(2'b00, 0, 0);
    applyStimulus(2'b00, 0, 0);
    checkOutput("ccw wrap d2 value", int'(dVal[2]), 255);
    checkOutput("ccw wrap d2 down", int'(dDn[2]), 1);
    checkOutput("ccw sat d0 value", int'(dVal[0]), 0);
    checkOutput("ccw sat d0 down", int'(dDn[0]), 1);
    checkOutput("ccw d1 value", int'(dVal[1]), 224);

    // Randomised walk with occasional holds, illegal jumps, clears and resets.
    applyStimulus(phTab[curPos], 0, 1);
    applyStimulus(phTab[curPos], 0, 0);
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(99);
      if (r < 45) curPos = (curPos + 1) % 4;
      else if (r < 80) curPos = (curPos + 3) % 4;
      else if (r < 94 && r >= 88) curPos = (curPos + 2) % 4;
      applyStimulus(phTab[curPos], ($urandom_range(49) == 0), ($urandom_range(199) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
